// File: rtl/lpc_record_framer.sv
// lpc_record_framer: pops fixed-width records from a ringbuffer and sends each
// one to a byte-wide UART as a framed, byte-stuffed packet.
//
// Frame format: 0x7E, then the DW/8 payload bytes MSB first, then (optionally)
// an XOR checksum of the unescaped payload bytes. Any payload or checksum byte
// equal to 0x7E or 0x7D is sent as 0x7D, (byte ^ 0x20). Each byte is followed
// by one dead cycle so the UART's ready flag has time to drop.
//
// Optional feature macro: LPC_FRAMER_CHECKSUM_EN. When defined, the checksum
// byte is appended to each frame; otherwise the frame ends after the payload.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous, active-low reset
//   read_empty         ringbuffer has no record
//   read_data[DW]      head record, valid while read_empty is low
//   read_clock_enable  one-cycle pop strobe to the ringbuffer
//   uart_ready         UART can take a byte
//   uart_data[8]       byte to transmit, held between strobes
//   uart_clock_enable  one-cycle load strobe to the UART
//   busy               high from the pop until the frame's last byte is issued
module lpc_record_framer #(
  parameter int unsigned DW = 48
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read_empty,
  input  logic [DW-1:0] read_data,
  output logic          read_clock_enable,
  input  logic          uart_ready,
  output logic [7:0]    uart_data,
  output logic          uart_clock_enable,
  output logic          busy
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_PAYLOAD,
    S_ESC2,
    S_GAP
`ifdef LPC_FRAMER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t          state_q;
  state_t          ret_q;      // state to resume after the GAP cycle
  state_t          esc_ret_q;  // state to resume after the escaped second byte
  logic [DW-1:0]   record_q;   // shifts left one byte per issued payload byte
  logic [IW-1:0]   idx_q;
  logic [7:0]      esc_q;      // pending second byte of an escape pair
`ifdef LPC_FRAMER_CHECKSUM_EN
  logic [7:0]      chk_q;
`endif

  logic [7:0]      cur_byte_c;
  logic            last_c;
  state_t          after_payload_c;

  // Current payload byte and where the FSM goes once it has been sent.
  always_comb begin
    cur_byte_c      = record_q[DW-1 -: 8];
    last_c          = (idx_q == IW'(NB - 1));
    after_payload_c = S_PAYLOAD;
    if (last_c) begin
`ifdef LPC_FRAMER_CHECKSUM_EN
      after_payload_c = S_CHECK;
`else
      after_payload_c = S_IDLE;
`endif
    end
  end

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == FLAG_BYTE) || (b == ESC_BYTE);
  endfunction

  // Framer FSM with registered strobes and data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      ret_q             <= S_IDLE;
      esc_ret_q         <= S_IDLE;
      record_q          <= '0;
      idx_q             <= '0;
      esc_q             <= 8'h00;
`ifdef LPC_FRAMER_CHECKSUM_EN
      chk_q             <= 8'h00;
`endif
      read_clock_enable <= 1'b0;
      uart_data         <= 8'h00;
      uart_clock_enable <= 1'b0;
      busy              <= 1'b0;
    end else begin
      read_clock_enable <= 1'b0;
      uart_clock_enable <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!read_empty) begin
            read_clock_enable <= 1'b1;
            record_q          <= read_data;
            idx_q             <= '0;
`ifdef LPC_FRAMER_CHECKSUM_EN
            chk_q             <= 8'h00;
`endif
            busy              <= 1'b1;
            state_q           <= S_POP;
          end
        end

        S_POP: begin
          state_q <= S_START;
        end

        S_START: begin
          if (uart_ready) begin
            uart_data         <= FLAG_BYTE;
            uart_clock_enable <= 1'b1;
            ret_q             <= S_PAYLOAD;
            state_q           <= S_GAP;
          end
        end

        S_PAYLOAD: begin
          if (uart_ready) begin
            record_q          <= record_q << 8;
            idx_q             <= last_c ? '0 : idx_q + IW'(1);
`ifdef LPC_FRAMER_CHECKSUM_EN
            chk_q             <= chk_q ^ cur_byte_c;
`endif
            uart_clock_enable <= 1'b1;
            state_q           <= S_GAP;
            if (needs_esc(cur_byte_c)) begin
              uart_data <= ESC_BYTE;
              esc_q     <= cur_byte_c ^ ESC_XOR;
              esc_ret_q <= after_payload_c;
              ret_q     <= S_ESC2;
            end else begin
              uart_data <= cur_byte_c;
              ret_q     <= after_payload_c;
            end
          end
        end

`ifdef LPC_FRAMER_CHECKSUM_EN
        S_CHECK: begin
          if (uart_ready) begin
            uart_clock_enable <= 1'b1;
            state_q           <= S_GAP;
            if (needs_esc(chk_q)) begin
              uart_data <= ESC_BYTE;
              esc_q     <= chk_q ^ ESC_XOR;
              esc_ret_q <= S_IDLE;
              ret_q     <= S_ESC2;
            end else begin
              uart_data <= chk_q;
              ret_q     <= S_IDLE;
            end
          end
        end
`endif

        S_ESC2: begin
          if (uart_ready) begin
            uart_data         <= esc_q;
            uart_clock_enable <= 1'b1;
            ret_q             <= esc_ret_q;
            state_q           <= S_GAP;
          end
        end

        S_GAP: begin
          // Leaving GAP for IDLE means the frame's last byte has gone out.
          state_q <= ret_q;
          if (ret_q == S_IDLE) begin
            busy <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_record_framer.sv
// Self-checking bench for lpc_record_framer: a queue-based ringbuffer, a
// frame-building reference model, directed vectors and randomized traffic.
module tb_lpc_record_framer;

  localparam int unsigned DW = 48;
  localparam int unsigned NB = DW / 8;

  logic          clock;
  logic          reset;
  logic          read_empty;
  logic [DW-1:0] read_data;
  logic          read_clock_enable;
  logic          uart_ready;
  logic [7:0]    uart_data;
  logic          uart_clock_enable;
  logic          busy;

  lpc_record_framer #(.DW(DW)) dut (
    .clock             (clock),
    .reset             (reset),
    .read_empty        (read_empty),
    .read_data         (read_data),
    .read_clock_enable (read_clock_enable),
    .uart_ready        (uart_ready),
    .uart_data         (uart_data),
    .uart_clock_enable (uart_clock_enable),
    .busy              (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];        // ringbuffer contents
  logic [7:0]    exp_q[$];    // bytes the model still expects on the UART
  logic [7:0]    got[$];      // bytes seen on the UART
  int            strobe_cyc[$];
  int            cyc = 0;
  int            pops = 0;
  int            ready_mode = 0;  // 0: always, 1: one cycle in ten, 2: random
  logic          rand_empty = 1'b0;
  logic          force_empty = 1'b0;
  logic          rdy_at_edge = 1'b0;
  logic          prev_uce = 1'b0;
  logic [7:0]    last_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic is_special(input logic [7:0] b);
    return (b == 8'h7E) || (b == 8'h7D);
  endfunction

  task automatic push_stuffed(input logic [7:0] b);
    if (is_special(b)) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  // Reference frame: flag, MSB-first payload, optional XOR checksum, all stuffed.
  task automatic push_frame(input logic [DW-1:0] rec);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'h7E);
    for (int i = 0; i < NB; i++) begin
      b = 8'(rec >> (8 * (NB - 1 - i)));
      x = x ^ b;
      push_stuffed(b);
    end
`ifdef LPC_FRAMER_CHECKSUM_EN
    push_stuffed(x);
`endif
  endtask

  function automatic int frame_len(input logic [DW-1:0] rec);
    int n;
    logic [7:0] b;
    logic [7:0] x;
    n = 1;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      b = 8'(rec >> (8 * (NB - 1 - i)));
      x = x ^ b;
      n += is_special(b) ? 2 : 1;
    end
`ifdef LPC_FRAMER_CHECKSUM_EN
    n += is_special(x) ? 2 : 1;
`endif
    return n;
  endfunction

  // Ringbuffer side: pop on strobe and load the model with the popped record.
  always @(posedge clock) begin
    logic [DW-1:0] rec;
    cyc++;
    rdy_at_edge = uart_ready;
    if (reset && read_clock_enable) begin
      check("pop_nonempty", q.size() != 0, 1'b1);
      check("pop_between_frames", exp_q.size() == 0, 1'b1);
      if (q.size() != 0) begin
        rec = q.pop_front();
        push_frame(rec);
      end
      pops++;
    end
  end

  // Input drivers, changed away from the active edge.
  always @(negedge clock) begin
    case (ready_mode)
      0:       uart_ready = 1'b1;
      1:       uart_ready = (cyc % 10 == 0);
      default: uart_ready = 1'($urandom_range(0, 1));
    endcase
    if (rand_empty) force_empty = ($urandom_range(0, 3) == 0);
    read_empty = force_empty || (q.size() == 0);
    read_data  = (q.size() != 0) ? q[0] : '0;
  end

  // UART monitor.
  always @(negedge clock) begin
    if (reset) begin
      if (uart_clock_enable) begin
        check("strobe_ready", rdy_at_edge, 1'b1);
        check("strobe_gap", prev_uce, 1'b0);
        check("byte_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("byte", uart_data, exp_q.pop_front());
        got.push_back(uart_data);
        strobe_cyc.push_back(cyc);
        last_data = uart_data;
      end else begin
        check("data_hold", uart_data, last_data);
      end
      if (exp_q.size() != 0) check("busy_in_frame", busy, 1'b1);
      prev_uce = uart_clock_enable;
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_rce", read_clock_enable, 1'b0);
    check("rst_uce", uart_clock_enable, 1'b0);
    check("rst_data", uart_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    exp_q.delete();
    last_data = 8'h00;
    prev_uce  = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!(q.size() == 0 && exp_q.size() == 0 && !busy) && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done"}, n < maxc, 1'b1);
  endtask

  function automatic logic [DW-1:0] rand_rec();
    logic [DW-1:0] r;
    int sel;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? 8'h7E : (sel == 1) ? 8'h7D : 8'($urandom);
      r = (r << 8) | DW'(b);
    end
    return r;
  endfunction

  typedef struct packed {
    logic [DW-1:0] rec;
    logic [79:0]   bytes;    // first byte in the top bits
    logic [3:0]    n_chk;
    logic [3:0]    n_nochk;
  } vec_t;

  vec_t vecs [3];

  initial begin
    vec_t v;
    logic [79:0] bv;
    int n;
    int len;
    logic [DW-1:0] rec_b;

    vecs[0] = '{rec: 48'h00000080_5A_01, bytes: 80'h7E_00_00_00_80_5A_01_DB_00_00, n_chk: 4'd8,  n_nochk: 4'd7};
    vecs[1] = '{rec: 48'h7E7D0000_00_00, bytes: 80'h7E_7D_5E_7D_5D_00_00_00_00_03, n_chk: 4'd10, n_nochk: 4'd9};
    vecs[2] = '{rec: 48'h00000000_7E_00, bytes: 80'h7E_00_00_00_00_7D_5E_00_7D_5E, n_chk: 4'd10, n_nochk: 4'd8};

    reset      = 1'b1;
    uart_ready = 1'b0;
    read_empty = 1'b1;
    read_data  = '0;
    do_reset();

    // Empty ringbuffer: nothing may move.
    force_empty = 1'b1;
    ready_mode  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("idle_quiet", {read_clock_enable, uart_clock_enable, busy}, 3'b000);
    end
    force_empty = 1'b0;

    // Directed vectors, UART always ready.
    for (int k = 0; k < 3; k++) begin
      v = vecs[k];
      got.delete();
      strobe_cyc.delete();
      pops = 0;
      q.push_back(v.rec);
      wait_idle(200, "vec");
`ifdef LPC_FRAMER_CHECKSUM_EN
      len = int'(v.n_chk);
`else
      len = int'(v.n_nochk);
`endif
      check("vec_len", got.size(), len);
      check("vec_pops", pops, 1);
      bv = v.bytes;
      for (int i = 0; i < len && i < got.size(); i++) check("vec_byte", got[i], bv[79 - 8*i -: 8]);
      if (strobe_cyc.size() == len) check("vec_rate", strobe_cyc[len-1] - strobe_cyc[0], 2 * (len - 1));
      check("vec_idle", busy, 1'b0);
    end

    // Three records against a mostly-unready UART.
    ready_mode = 1;
    got.delete();
    pops = 0;
    len = 0;
    for (int k = 0; k < 3; k++) begin
      q.push_back(vecs[k].rec);
      len += frame_len(vecs[k].rec);
    end
    wait_idle(3000, "slow");
    check("slow_pops", pops, 3);
    check("slow_len", got.size(), len);

    // Reset after the fourth byte of a frame; next record must start fresh.
    ready_mode = 0;
    got.delete();
    rec_b = 48'h0123_4567_89AB;
    q.push_back(vecs[0].rec);
    q.push_back(rec_b);
    n = 0;
    while (got.size() < 4 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("rst4_reached", got.size() >= 4, 1'b1);
    do_reset();
    got.delete();
    check("rst4_queued", q.size(), 1);
    wait_idle(200, "rst4");
    check("rst4_len", got.size(), frame_len(rec_b));
    if (got.size() != 0) check("rst4_flag", got[0], 8'h7E);

    // Randomized traffic with a flickering read_empty.
    ready_mode = 2;
    rand_empty = 1'b1;
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      q.push_back(rand_rec());
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 30)) @(negedge clock);
    end
    wait_idle(20000, "rand");
    check("rand_pops", pops, 40);
    rand_empty  = 1'b0;
    force_empty = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lpc_record_framer.md
LPC_RECORD_FRAMER -- requirements
Module: lpc_record_framer

Interface
REQ-001 SHALL have parameter DW, default 48, record width in bits; must be a multiple of 8.
REQ-002 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port read_empty  input  1  ringbuffer holds no record.
REQ-005 SHALL have port read_data  input  DW  head record, valid whenever read_empty is low.
REQ-006 SHALL have port read_clock_enable  output  1  one-cycle pop strobe to ringbuffer.
REQ-007 SHALL have port uart_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-008 SHALL have port uart_data  output  8  byte to transmit.
REQ-009 SHALL have port uart_clock_enable  output  1  one-cycle load strobe to UART.
REQ-010 SHALL have port busy  output  1  high from pop until the last byte of the frame is issued.

Function
REQ-011 SHALL run an FSM with states IDLE, POP, START, PAYLOAD, ESC2, CHECK, GAP.
REQ-012 IDLE: when read_empty is low, assert read_clock_enable for exactly one cycle, capture read_data into the record register on the same edge, then go to POP.
REQ-013 SHALL never assert read_clock_enable while read_empty is high or while a frame is in progress.
REQ-014 Byte order: payload bytes MSB first, i.e. record[DW-1:DW-8] first and record[7:0] last; byte index counter runs 0..DW/8-1.
REQ-015 START issues 0x7E unescaped; every payload and checksum byte equal to 0x7E or 0x7D SHALL be sent as 0x7D followed by (byte XOR 0x20), the second byte issued from ESC2.
REQ-016 A byte SHALL be issued only in a cycle where uart_ready is high: uart_data valid and uart_clock_enable high for exactly that one cycle.
REQ-017 After each issued byte the FSM SHALL spend exactly one cycle in GAP, ignoring uart_ready, then return to the state that issues the next byte.
REQ-018 Checksum = XOR of the DW/8 unescaped payload bytes, accumulated as bytes are issued.
REQ-019 After the final byte of the frame SHALL return to IDLE; minimum gap between two frames' pop strobes is set by uart_ready only, with no extra idle cycles.
REQ-020 busy SHALL be low in IDLE and high in every other state.
REQ-021 uart_data SHALL hold its last value when uart_clock_enable is low.
REQ-022 A record arriving while read_empty toggles mid-frame SHALL remain queued in the ringbuffer; the framer never drops or reorders records.

Reset
REQ-023 While reset is low: state IDLE, read_clock_enable 0, uart_clock_enable 0, uart_data 0x00, busy 0, byte index 0, checksum 0, record register 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame immediately. No further bytes of it are sent. The popped record is lost. The next frame begins with 0x7E so the host resynchronises.

Configuration
REQ-025 With LPC_FRAMER_CHECKSUM_EN defined: CHECK state appends the escaped checksum byte after the last payload byte.
REQ-026 Without LPC_FRAMER_CHECKSUM_EN: CHECK state and checksum register SHALL be absent. The frame ends after the last payload byte.

Verification
REQ-027 Record 0x00000080_5A_01, uart_ready always high, checksum on -> bytes 7E 00 00 00 80 5A 01 DB, one strobe every 2 cycles, single pop.
REQ-028 Record 0x7E7D0000_00_00 -> 7E 7D 5E 7D 5D 00 00 00 00 03 (checksum on); same without macro -> identical minus trailing 03.
REQ-029 Record 0x00000000_7E_00 -> 7E 00 00 00 00 7D 5E 00 7D 5E, checksum itself escaped.
REQ-030 Three records queued, uart_ready low 9 of every 10 cycles -> three complete frames in order, no strobe while uart_ready low, exactly three pops.
REQ-031 Reset pulsed low after the 4th byte of a frame -> outputs zero within the same cycle, no further bytes; next queued record yields a fresh frame starting 7E.
REQ-032 read_empty held high for 100 cycles after reset -> read_clock_enable, uart_clock_enable and busy remain 0 throughout.
